// File: rtl/pattern_generator.sv
// pattern_generator: timed pattern source for one game.
// Each game_clk pulse carries either a fresh nonzero LFSR-derived pattern
// or an all-zero gap pattern. The tempo speeds up after every nonzero
// pattern, and the game ends after NUM_ROUNDS nonzero patterns.
module pattern_generator #(
    parameter int unsigned TICK_CYCLES     = 25000000,
    parameter int unsigned MIN_TICK_CYCLES = 5000000,
    parameter int unsigned STEP_CYCLES     = 1000000,
    parameter int unsigned GAP_TICKS       = 3,
    parameter int unsigned NUM_ROUNDS      = 20,
    parameter logic [15:0] SEED            = 16'hACE1
) (
    input  logic       CLOCK50M,
    input  logic       reset,
    input  logic       start,
    input  logic       enable,
    output logic       game_clk,
    output logic [7:0] pattern,
    output logic [7:0] round,
    output logic       busy,
    output logic       game_over
);

    // An all-zero LFSR would lock up, so a zero seed falls back to ACE1.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [31:0] TICK_P   = TICK_CYCLES;
    localparam logic [31:0] MIN_P    = MIN_TICK_CYCLES;
    localparam logic [31:0] STEP_P   = STEP_CYCLES;
    localparam logic [31:0] GAP_P    = GAP_TICKS;
    localparam logic [7:0]  ROUNDS_P = 8'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] period_q, period_d;
    logic [31:0] gap_q, gap_d;
    logic [7:0]  round_q, round_d;
    logic [7:0]  pattern_q, pattern_d;
    logic        gclk_q, gclk_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [7:0]  cand;
    logic [31:0] period_next;

    // LFSR step (x^16+x^14+x^13+x^11+1), candidate pattern and next period.
    always_comb begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        cand   = (lfsr_q[7:0] == 8'h00) ? 8'h01 : lfsr_q[7:0];
        // Saturating subtract: never underflows when the step exceeds the period.
        period_next = MIN_P;
        if ((period_q > STEP_P) && ((period_q - STEP_P) > MIN_P)) begin
            period_next = period_q - STEP_P;
        end
    end

    // LFSR free-runs every cycle outside reset, so patterns depend on start timing.
    always_ff @(posedge CLOCK50M) begin
        if (reset) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Game FSM next-state, tick timing, pattern and round update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        gap_d     = gap_q;
        round_d   = round_q;
        pattern_d = pattern_q;
        gclk_d    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    round_d   = '0;
                    period_d  = TICK_P;
                    cnt_d     = '0;
                    gap_d     = '0;
                    pattern_d = '0;
                end
            end
            RUN: begin
                if (enable) begin
                    if (cnt_q == period_q - 32'd1) begin
                        cnt_d  = '0;
                        gclk_d = 1'b1;
                        if ((gap_q == '0) && (round_q < ROUNDS_P)) begin
                            pattern_d = cand;
                            round_d   = round_q + 8'd1;
                            gap_d     = GAP_P;
                            period_d  = period_next;
                        end else if (gap_q != '0) begin
                            pattern_d = '0;
                            gap_d     = gap_q - 32'd1;
                        end
                        if ((round_d == ROUNDS_P) && (gap_d == '0)) begin
                            state_d = DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLOCK50M) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= TICK_P;
            gap_q     <= '0;
            round_q   <= '0;
            pattern_q <= '0;
            gclk_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            gap_q     <= gap_d;
            round_q   <= round_d;
            pattern_q <= pattern_d;
            gclk_q    <= gclk_d;
        end
    end

    assign game_clk  = gclk_q;
    assign pattern   = pattern_q;
    assign round     = round_q;
    assign busy      = (state_q == RUN);
    assign game_over = (state_q == DONE);

endmodule

// File: tb/tb_pattern_generator.sv
// Directed testbench for pattern_generator with small timing parameters.
// dut1 uses the main parameter set; dut2 uses SEED=0 and a step larger
// than the period so the period saturates right after the first pattern.
module tb_pattern_generator;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       start  = 1'b0;
    logic       enable = 1'b0;
    logic       g1, g2, b1, b2, o1, o2;
    logic [7:0] p1, p2, r1, r2;

    int checks = 0;
    int errors = 0;

    // Schedules of expected ticks: cycle, nonzero flag, round after tick.
    int         s1_t[$];
    bit         s1_nz[$];
    logic [7:0] s1_r[$];
    int         s2_t[$];
    bit         s2_nz[$];
    logic [7:0] s2_r[$];

    int pause_lo, pause_hi, start_at, reset_at, game_end, game_end2;
    bit chk2;

    // Reference LFSR; lfsr_prev holds the value the DUT used at the last edge.
    logic [15:0] lfsr_m    = 16'hACE1;
    logic [15:0] lfsr_prev = 16'hACE1;

    always #5 clk = ~clk;

    pattern_generator #(
        .TICK_CYCLES(10), .MIN_TICK_CYCLES(4), .STEP_CYCLES(2),
        .GAP_TICKS(2), .NUM_ROUNDS(3), .SEED(16'hACE1)
    ) dut (
        .CLOCK50M(clk), .reset(reset), .start(start), .enable(enable),
        .game_clk(g1), .pattern(p1), .round(r1), .busy(b1), .game_over(o1)
    );

    pattern_generator #(
        .TICK_CYCLES(10), .MIN_TICK_CYCLES(4), .STEP_CYCLES(20),
        .GAP_TICKS(2), .NUM_ROUNDS(3), .SEED(16'h0000)
    ) dut2 (
        .CLOCK50M(clk), .reset(reset), .start(start), .enable(enable),
        .game_clk(g2), .pattern(p2), .round(r2), .busy(b2), .game_over(o2)
    );

    // Reference LFSR model.
    always @(posedge clk) begin
        lfsr_prev <= lfsr_m;
        lfsr_m    <= reset ? 16'hACE1
                           : {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
    end

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] cand(input logic [15:0] v);
        return (v[7:0] == 8'h00) ? 8'h01 : v[7:0];
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_main_sched();
        s1_t  = '{10, 18, 26, 34, 40, 46, 52, 56, 60};
        s1_nz = '{1, 0, 0, 1, 0, 0, 1, 0, 0};
        s1_r  = '{8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd3, 8'd3, 8'd3};
    endtask

    // Start a game, then step n cycles checking every output each cycle.
    task automatic run_game(input int n);
        logic [7:0] ep1 = 8'h00, er1 = 8'h00, ep2 = 8'h00, er2 = 8'h00;
        int idx;
        bit fin;
        start  = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk8("start_round", r1, 8'h00);
        chk8("start_pattern", p1, 8'h00);
        chk1("start_busy", b1, 1'b1);
        chk1("start_over", o1, 1'b0);
        chk1("start_gclk", g1, 1'b0);
        if (chk2) begin
            chk8("d2_start_round", r2, 8'h00);
            chk1("d2_start_busy", b2, 1'b1);
        end
        for (int c = 1; c <= n; c++) begin
            enable = !(c >= pause_lo && c <= pause_hi);
            start  = (c == start_at);
            reset  = (c == reset_at);
            @(negedge clk);
            start = 1'b0;
            if (c == reset_at) begin
                reset = 1'b0;
                chk8($sformatf("rst_pattern@%0d", c), p1, 8'h00);
                chk8($sformatf("rst_round@%0d", c), r1, 8'h00);
                chk1($sformatf("rst_busy@%0d", c), b1, 1'b0);
                chk1($sformatf("rst_over@%0d", c), o1, 1'b0);
                chk1($sformatf("rst_gclk@%0d", c), g1, 1'b0);
                return;
            end
            idx = -1;
            foreach (s1_t[i]) if (s1_t[i] == c) idx = i;
            if (idx >= 0) begin
                ep1 = s1_nz[idx] ? cand(lfsr_prev) : 8'h00;
                er1 = s1_r[idx];
            end
            fin = (game_end >= 0) && (c >= game_end);
            chk1($sformatf("gclk@%0d", c), g1, idx >= 0);
            chk8($sformatf("pattern@%0d", c), p1, ep1);
            chk8($sformatf("round@%0d", c), r1, er1);
            chk1($sformatf("busy@%0d", c), b1, !fin);
            chk1($sformatf("over@%0d", c), o1, fin);
            if (chk2) begin
                idx = -1;
                foreach (s2_t[i]) if (s2_t[i] == c) idx = i;
                if (idx >= 0) begin
                    ep2 = s2_nz[idx] ? cand(lfsr_prev) : 8'h00;
                    er2 = s2_r[idx];
                end
                fin = (c >= game_end2);
                chk1($sformatf("d2_gclk@%0d", c), g2, idx >= 0);
                chk8($sformatf("d2_pattern@%0d", c), p2, ep2);
                chk8($sformatf("d2_round@%0d", c), r2, er2);
                chk1($sformatf("d2_over@%0d", c), o2, fin);
            end
        end
    endtask

    initial begin
        pause_lo  = 1000;
        pause_hi  = 0;
        start_at  = -1;
        reset_at  = -1;
        game_end  = -1;
        game_end2 = -1;
        chk2      = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk1("reset_gclk", g1, 1'b0);
        chk8("reset_pattern", p1, 8'h00);
        chk8("reset_round", r1, 8'h00);
        chk1("reset_busy", b1, 1'b0);
        chk1("reset_over", o1, 1'b0);
        chk1("reset_d2_busy", b2, 1'b0);

        // Start together with reset: reset wins.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        chk1("rst_start_busy", b1, 1'b0);
        @(negedge clk);
        chk1("idle_busy", b1, 1'b0);
        chk1("idle_gclk", g1, 1'b0);

        // Full game; dut2 checks saturated period and zero seed.
        set_main_sched();
        s2_t  = '{10, 14, 18, 22, 26, 30, 34, 38, 42};
        s2_nz = '{1, 0, 0, 1, 0, 0, 1, 0, 0};
        s2_r  = '{8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd3, 8'd3, 8'd3};
        game_end  = 60;
        game_end2 = 42;
        chk2      = 1'b1;
        run_game(70);

        // Restart from DONE; a start pulse during RUN is ignored.
        chk2     = 1'b0;
        start_at = 20;
        run_game(64);

        // Reset during the gap after the first pattern.
        start_at = -1;
        reset_at = 30;
        game_end = -1;
        run_game(30);
        reset_at = -1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk1($sformatf("post_rst_gclk%0d", c), g1, 1'b0);
            chk1($sformatf("post_rst_busy%0d", c), b1, 1'b0);
        end

        // New game after reset, with a 7-cycle pause between ticks 18 and 26.
        s1_t     = '{10, 18, 33, 41};
        s1_nz    = '{1, 0, 0, 1};
        s1_r     = '{8'd1, 8'd1, 8'd1, 8'd2};
        pause_lo = 20;
        pause_hi = 26;
        run_game(45);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
